// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multi-cycle control FSM and the datapath/memory side.
// The master side is the control FSM; the slave side is the datapath and shared memory.
interface multicycle_control_fsm_if;
    logic [6:0] opcode_i;
    logic       mem_ready_i;
    logic       mem_req_o;
    logic       AdrSrc_o;
    logic       MemWrite_o;
    logic       IRWrite_o;
    logic       PCWrite_o;
    logic       Branch_o;
    logic       RegWrite_o;
    logic [1:0] ALUSrcA_o;
    logic [1:0] ALUSrcB_o;
    logic [1:0] ALUOp_o;
    logic [1:0] ResultSrc_o;
    logic [2:0] ImmSrc_o;
    logic       retire_o;
    logic       fault_o;
    logic [1:0] fault_code_o;

    modport master (
        input  opcode_i, mem_ready_i,
        output mem_req_o, AdrSrc_o, MemWrite_o, IRWrite_o, PCWrite_o, Branch_o,
               RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, ResultSrc_o, ImmSrc_o,
               retire_o, fault_o, fault_code_o
    );

    modport slave (
        output opcode_i, mem_ready_i,
        input  mem_req_o, AdrSrc_o, MemWrite_o, IRWrite_o, PCWrite_o, Branch_o,
               RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, ResultSrc_o, ImmSrc_o,
               retire_o, fault_o, fault_code_o
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit. Sequences each instruction through fetch, decode,
// execute, memory and writeback states, handshakes with a shared instruction/data
// memory and drives the datapath mux/enable controls as a Moore decode of the state.
// Illegal opcodes and memory wait timeouts park the FSM in a sticky FAULT state.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter bit TIMEOUT_EN  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    multicycle_control_fsm_if.master  bus
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    typedef enum logic [4:0] {
        S_IDLE     = 5'd0,
        S_FETCH    = 5'd1,
        S_DECODE   = 5'd2,
        S_MEMADR   = 5'd3,
        S_MEMREAD  = 5'd4,
        S_MEMWB    = 5'd5,
        S_MEMWRITE = 5'd6,
        S_EXECR    = 5'd7,
        S_EXECI    = 5'd8,
        S_LUI      = 5'd9,
        S_AUIPC    = 5'd10,
        S_ALUWB    = 5'd11,
        S_BRANCH   = 5'd12,
        S_JAL      = 5'd13,
        S_JALR     = 5'd14,
        S_LINK     = 5'd15,
        S_FAULT    = 5'd16
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fault_code_q, fault_code_d;

    logic             is_mem_s;
    logic             timeout_s;

    // Immediate format selected by the instruction's opcode.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        logic [2:0] imm;
        case (op)
            OP_LOAD, OP_ITYPE, OP_JALR: imm = 3'b000;
            OP_STORE:                   imm = 3'b001;
            OP_BRANCH:                  imm = 3'b010;
            OP_LUI, OP_AUIPC:           imm = 3'b011;
            OP_JAL:                     imm = 3'b100;
            default:                    imm = 3'b000;
        endcase
        return imm;
    endfunction

    // State, wait counter and fault code registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            fault_code_q <= FC_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fault_code_q <= fault_code_d;
        end
    end

    // Next-state, memory wait counter and fault detection.
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        fault_code_d = fault_code_q;

        is_mem_s  = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
        // A ready arriving on the limit cycle still completes the access.
        timeout_s = TIMEOUT_EN && is_mem_s && !bus.mem_ready_i && (cnt_q == CNT_MAX);

        // Counter only runs while a memory state waits; leaving or completing clears it.
        if (is_mem_s && !bus.mem_ready_i && !timeout_s) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = '0;
        end

        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready_i) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (bus.opcode_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default: begin
                        state_d      = S_FAULT;
                        fault_code_d = FC_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                if (bus.opcode_i == OP_LOAD) begin
                    state_d = S_MEMREAD;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                if (bus.mem_ready_i) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWRITE: begin
                if (bus.mem_ready_i) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXECR, S_EXECI, S_LUI, S_AUIPC: state_d = S_ALUWB;
            S_BRANCH: state_d = S_FETCH;
            S_JAL:    state_d = S_ALUWB;
            S_JALR:   state_d = S_LINK;
            S_LINK:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
        endcase

        if (timeout_s) begin
            state_d      = S_FAULT;
            fault_code_d = FC_TIMEOUT;
        end
    end

    // Moore decode of the control outputs; fetch write enables wait for memory ready.
    always_comb begin
        bus.mem_req_o    = 1'b0;
        bus.AdrSrc_o     = 1'b0;
        bus.MemWrite_o   = 1'b0;
        bus.IRWrite_o    = 1'b0;
        bus.PCWrite_o    = 1'b0;
        bus.Branch_o     = 1'b0;
        bus.RegWrite_o   = 1'b0;
        bus.ALUSrcA_o    = 2'b00;
        bus.ALUSrcB_o    = 2'b00;
        bus.ALUOp_o      = 2'b00;
        bus.ResultSrc_o  = 2'b00;
        bus.ImmSrc_o     = 3'b000;
        bus.retire_o     = 1'b0;
        bus.fault_o      = 1'b0;
        bus.fault_code_o = fault_code_q;

        if ((state_q != S_IDLE) && (state_q != S_FAULT)) begin
            bus.ImmSrc_o = imm_src_of(bus.opcode_i);
        end else begin
            bus.ImmSrc_o = 3'b000;
        end

        case (state_q)
            S_FETCH: begin
                bus.mem_req_o   = 1'b1;
                bus.ALUSrcB_o   = 2'b10;
                bus.ResultSrc_o = 2'b10;
                bus.IRWrite_o   = bus.mem_ready_i;
                bus.PCWrite_o   = bus.mem_ready_i;
            end
            S_DECODE: begin
                bus.ALUSrcA_o = 2'b01;
                bus.ALUSrcB_o = 2'b01;
            end
            S_MEMADR: begin
                bus.ALUSrcA_o = 2'b10;
                bus.ALUSrcB_o = 2'b01;
            end
            S_MEMREAD: begin
                bus.mem_req_o = 1'b1;
                bus.AdrSrc_o  = 1'b1;
            end
            S_MEMWB: begin
                bus.ResultSrc_o = 2'b01;
                bus.RegWrite_o  = 1'b1;
                bus.retire_o    = 1'b1;
            end
            S_MEMWRITE: begin
                bus.mem_req_o  = 1'b1;
                bus.AdrSrc_o   = 1'b1;
                bus.MemWrite_o = 1'b1;
                bus.retire_o   = bus.mem_ready_i;
            end
            S_EXECR: begin
                bus.ALUSrcA_o = 2'b10;
                bus.ALUOp_o   = 2'b10;
            end
            S_EXECI: begin
                bus.ALUSrcA_o = 2'b10;
                bus.ALUSrcB_o = 2'b01;
                bus.ALUOp_o   = 2'b10;
            end
            S_LUI: begin
                bus.ALUSrcB_o = 2'b01;
                bus.ALUOp_o   = 2'b11;
            end
            S_AUIPC: begin
                bus.ALUSrcA_o = 2'b01;
                bus.ALUSrcB_o = 2'b01;
            end
            S_BRANCH: begin
                bus.ALUSrcA_o = 2'b10;
                bus.ALUOp_o   = 2'b01;
                bus.Branch_o  = 1'b1;
                bus.retire_o  = 1'b1;
            end
            S_JAL: begin
                bus.PCWrite_o = 1'b1;
                bus.ALUSrcA_o = 2'b01;
                bus.ALUSrcB_o = 2'b10;
            end
            S_JALR: begin
                bus.ALUSrcA_o   = 2'b10;
                bus.ALUSrcB_o   = 2'b01;
                bus.ResultSrc_o = 2'b10;
                bus.PCWrite_o   = 1'b1;
            end
            S_LINK: begin
                bus.ALUSrcA_o = 2'b01;
                bus.ALUSrcB_o = 2'b10;
            end
            S_ALUWB: begin
                bus.RegWrite_o = 1'b1;
                bus.retire_o   = 1'b1;
            end
            S_FAULT: begin
                bus.fault_o = 1'b1;
            end
            default: begin
                bus.fault_o = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed testbench for multicycle_control_fsm. Outputs are packed into one vector:
// {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, Branch, RegWrite | ALUSrcA | ALUSrcB |
//  ALUOp | ResultSrc | ImmSrc | retire, fault | fault_code}
module tb_multicycle_control_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    multicycle_control_fsm_if bus0 ();
    multicycle_control_fsm_if bus4 ();

    multicycle_control_fsm dut0 (.clk(clk), .rst(rst), .bus(bus0));
    multicycle_control_fsm #(.MEM_TIMEOUT(4), .TIMEOUT_EN(1'b1)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;

    logic [21:0] obs0, obs4;
    assign obs0 = {bus0.mem_req_o, bus0.AdrSrc_o, bus0.MemWrite_o, bus0.IRWrite_o, bus0.PCWrite_o,
                   bus0.Branch_o, bus0.RegWrite_o, bus0.ALUSrcA_o, bus0.ALUSrcB_o, bus0.ALUOp_o,
                   bus0.ResultSrc_o, bus0.ImmSrc_o, bus0.retire_o, bus0.fault_o, bus0.fault_code_o};
    assign obs4 = {bus4.mem_req_o, bus4.AdrSrc_o, bus4.MemWrite_o, bus4.IRWrite_o, bus4.PCWrite_o,
                   bus4.Branch_o, bus4.RegWrite_o, bus4.ALUSrcA_o, bus4.ALUSrcB_o, bus4.ALUOp_o,
                   bus4.ResultSrc_o, bus4.ImmSrc_o, bus4.retire_o, bus4.fault_o, bus4.fault_code_o};

    // Pulse reset across one negedge; returns #1 after release with both DUTs in IDLE.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (obs0 !== 22'd0) begin
            $display("FAIL reset_dut0: got %b want %b", obs0, 22'd0);
            fails++;
        end
        checks++;
        if (obs4 !== 22'd0) begin
            $display("FAIL reset_dut4: got %b want %b", obs4, 22'd0);
            fails++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_rtype();
        logic [21:0] exp_t [0:5];
        exp_t = '{22'b0000000_00_00_00_00_000_00_00,   // IDLE
                  22'b1001100_00_10_00_10_000_00_00,   // FETCH ready
                  22'b0000000_01_01_00_00_000_00_00,   // DECODE
                  22'b0000000_10_00_10_00_000_00_00,   // EXECR
                  22'b0000001_00_00_00_00_000_10_00,   // ALUWB retire
                  22'b1001100_00_10_00_10_000_00_00};  // FETCH
        bus0.opcode_i = 7'b0110011;
        bus0.mem_ready_i = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i != 0) begin
                @(negedge clk);
                #1;
            end
            checks++;
            if (obs0 !== exp_t[i]) begin
                $display("FAIL rtype[%0d]: got %b want %b", i, obs0, exp_t[i]);
                fails++;
            end
        end
    endtask

    task automatic test_load_wait();
        logic [21:0] exp_t [0:8];
        logic [8:0]  rdy;
        exp_t = '{22'b1001100_00_10_00_10_000_00_00,   // FETCH
                  22'b0000000_01_01_00_00_000_00_00,   // DECODE
                  22'b0000000_10_01_00_00_000_00_00,   // MEMADR
                  22'b1100000_00_00_00_00_000_00_00,   // MEMREAD wait
                  22'b1100000_00_00_00_00_000_00_00,   // MEMREAD wait
                  22'b1100000_00_00_00_00_000_00_00,   // MEMREAD wait
                  22'b1100000_00_00_00_00_000_00_00,   // MEMREAD ready
                  22'b0000001_00_00_00_01_000_10_00,   // MEMWB retire
                  22'b1001100_00_10_00_10_000_00_00};  // FETCH
        rdy = 9'b111_000_111; // bit i = ready in cycle i
        rdy = 9'b1_1100_0111;
        bus0.opcode_i = 7'b0000011;
        bus0.mem_ready_i = 1'b1;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus0.mem_ready_i = rdy[i];
            #1;
            checks++;
            if (obs0 !== exp_t[i]) begin
                $display("FAIL load_wait[%0d]: got %b want %b", i, obs0, exp_t[i]);
                fails++;
            end
        end
    endtask

    task automatic test_illegal();
        logic [21:0] e_fetch, e_dec, e_fault;
        e_fetch = 22'b1001100_00_10_00_10_000_00_00;
        e_dec   = 22'b0000000_01_01_00_00_000_00_00;
        e_fault = 22'b0000000_00_00_00_00_000_01_01;
        bus0.opcode_i = 7'b1111111;
        bus0.mem_ready_i = 1'b1;
        do_reset();
        @(negedge clk);
        #1;
        checks++;
        if (obs0 !== e_fetch) begin
            $display("FAIL illegal_fetch: got %b want %b", obs0, e_fetch);
            fails++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs0 !== e_dec) begin
            $display("FAIL illegal_decode: got %b want %b", obs0, e_dec);
            fails++;
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus0.mem_ready_i = (i % 2 == 0);
            #1;
            checks++;
            if (obs0 !== e_fault) begin
                $display("FAIL illegal_fault[%0d]: got %b want %b", i, obs0, e_fault);
                fails++;
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (obs0 !== 22'd0) begin
            $display("FAIL illegal_rst_clears: got %b want %b", obs0, 22'd0);
            fails++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_timeout();
        logic [21:0] e_wait, e_tmo, e_fetch, e_dec;
        e_wait  = 22'b1000000_00_10_00_10_000_00_00;
        e_tmo   = 22'b0000000_00_00_00_00_000_01_10;
        e_fetch = 22'b1001100_00_10_00_10_000_00_00;
        e_dec   = 22'b0000000_01_01_00_00_000_00_00;
        bus0.opcode_i = 7'b0110011;
        bus4.opcode_i = 7'b0110011;
        bus0.mem_ready_i = 1'b0;
        bus4.mem_ready_i = 1'b0;
        do_reset();
        // Never ready: limit 4 faults on the 6th FETCH-side cycle, limit 15 on the 17th.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (obs4 !== ((i < 5) ? e_wait : e_tmo)) begin
                $display("FAIL timeout4[%0d]: got %b want %b", i, obs4, (i < 5) ? e_wait : e_tmo);
                fails++;
            end
            checks++;
            if (obs0 !== ((i < 16) ? e_wait : e_tmo)) begin
                $display("FAIL timeout15[%0d]: got %b want %b", i, obs0, (i < 16) ? e_wait : e_tmo);
                fails++;
            end
        end
        // Ready arrives on the limit cycle: no fault.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus4.mem_ready_i = (i == 4);
            #1;
            checks++;
            if (obs4 !== ((i < 4) ? e_wait : e_fetch)) begin
                $display("FAIL ready_at_limit[%0d]: got %b want %b", i, obs4, (i < 4) ? e_wait : e_fetch);
                fails++;
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs4 !== e_dec) begin
            $display("FAIL ready_at_limit_decode: got %b want %b", obs4, e_dec);
            fails++;
        end
        bus4.mem_ready_i = 1'b0;
    endtask

    task automatic test_jalr();
        logic [21:0] exp_t [0:5];
        exp_t = '{22'b1001100_00_10_00_10_000_00_00,   // FETCH
                  22'b0000000_01_01_00_00_000_00_00,   // DECODE
                  22'b0000100_10_01_00_10_000_00_00,   // JALR: PCWrite, ResultSrc 10
                  22'b0000000_01_10_00_00_000_00_00,   // LINK: A OldPC, B 4
                  22'b0000001_00_00_00_00_000_10_00,   // ALUWB
                  22'b1001100_00_10_00_10_000_00_00};  // FETCH
        bus0.opcode_i = 7'b1100111;
        bus0.mem_ready_i = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (obs0 !== exp_t[i]) begin
                $display("FAIL jalr[%0d]: got %b want %b", i, obs0, exp_t[i]);
                fails++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] exp_t [0:14];
        logic [6:0]  op_t  [0:14];
        exp_t = '{22'b1001100_00_10_00_10_001_00_00,   // FETCH (store)
                  22'b0000000_01_01_00_00_001_00_00,   // DECODE
                  22'b0000000_10_01_00_00_001_00_00,   // MEMADR
                  22'b1110000_00_00_00_00_001_10_00,   // MEMWRITE ready, retire
                  22'b1001100_00_10_00_10_010_00_00,   // FETCH (branch)
                  22'b0000000_01_01_00_00_010_00_00,   // DECODE
                  22'b0000010_10_00_01_00_010_10_00,   // BRANCH retire
                  22'b1001100_00_10_00_10_011_00_00,   // FETCH (lui)
                  22'b0000000_01_01_00_00_011_00_00,   // DECODE
                  22'b0000000_00_01_11_00_011_00_00,   // LUI pass B
                  22'b0000001_00_00_00_00_011_10_00,   // ALUWB
                  22'b1001100_00_10_00_10_100_00_00,   // FETCH (jal)
                  22'b0000000_01_01_00_00_100_00_00,   // DECODE
                  22'b0000100_01_10_00_00_100_00_00,   // JAL
                  22'b0000001_00_00_00_00_100_10_00};  // ALUWB
        op_t = '{7'b0100011, 7'b0100011, 7'b0100011, 7'b0100011,
                 7'b1100011, 7'b1100011, 7'b1100011,
                 7'b0110111, 7'b0110111, 7'b0110111, 7'b0110111,
                 7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111};
        bus0.opcode_i = 7'b0100011;
        bus0.mem_ready_i = 1'b1;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus0.opcode_i = op_t[i];
            #1;
            checks++;
            if (obs0 !== exp_t[i]) begin
                $display("FAIL back_to_back[%0d]: got %b want %b", i, obs0, exp_t[i]);
                fails++;
            end
        end
    endtask

    task automatic test_store_reset();
        logic [21:0] exp_t [0:4];
        logic [21:0] e_fetch;
        exp_t = '{22'b1001100_00_10_00_10_001_00_00,   // FETCH
                  22'b0000000_01_01_00_00_001_00_00,   // DECODE
                  22'b0000000_10_01_00_00_001_00_00,   // MEMADR
                  22'b1110000_00_00_00_00_001_00_00,   // MEMWRITE waiting
                  22'b1110000_00_00_00_00_001_00_00};  // MEMWRITE waiting
        e_fetch = 22'b1001100_00_10_00_10_001_00_00;
        bus0.opcode_i = 7'b0100011;
        bus0.mem_ready_i = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus0.mem_ready_i = (i < 3);
            #1;
            checks++;
            if (obs0 !== exp_t[i]) begin
                $display("FAIL store_pre_rst[%0d]: got %b want %b", i, obs0, exp_t[i]);
                fails++;
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (obs0 !== 22'd0) begin
            $display("FAIL store_rst_async: got %b want %b", obs0, 22'd0);
            fails++;
        end
        @(negedge clk);
        rst = 1'b0;
        bus0.mem_ready_i = 1'b1;
        #1;
        checks++;
        if (obs0 !== 22'd0) begin
            $display("FAIL store_rst_idle: got %b want %b", obs0, 22'd0);
            fails++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs0 !== e_fetch) begin
            $display("FAIL store_rst_refetch: got %b want %b", obs0, e_fetch);
            fails++;
        end
    endtask

    initial begin
        bus0.opcode_i    = 7'b0000000;
        bus0.mem_ready_i = 1'b0;
        bus4.opcode_i    = 7'b0110011;
        bus4.mem_ready_i = 1'b0;
        test_reset();
        test_rtype();
        test_load_wait();
        test_illegal();
        test_timeout();
        test_jalr();
        test_back_to_back();
        test_store_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
